vertex_fetch_reader: RTL and testbench

Avalon-side read master that fetches packed vertex records (three consecutive 32-bit words: x, y, z) from the 1024×32 single-port on-chip memory. It assembles each record into a vertex beat and streams it downstream to the transform stage over a valid/ready handshake. It sits directly on the memory's s1 port and owns all read traffic to it while busy.

---
 rtl/vertex_fetch_reader.sv | 223 ++++++++++++++++++++++
 tb/tb_vertex_fetch_reader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vertex_fetch_reader.sv
`default_nettype none
// ============================================================================
// Module   : vertex_fetch_reader
// Purpose  : Read master for the 1024x32 single-port on-chip memory. Fetches
//            packed vertex records (x, y, z in three consecutive words),
//            assembles each one into a single beat and streams it downstream
//            over a valid/ready handshake.
// Ports    : clk, reset_n (async, active-low)
//            start / base_addr / vertex_count -> job request (sampled in IDLE)
//            busy / done                      -> job status
//            mem_*                            -> memory s1 port (read only)
//            vtx_valid / vtx_ready / vtx_x/y/z / vtx_last -> vertex stream
// Revision : 1.0 - initial release
// ============================================================================
module vertex_fetch_reader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [9:0]        vertex_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              vtx_valid,
  input  logic              vtx_ready,
  output logic [DATA_W-1:0] vtx_x,
  output logic [DATA_W-1:0] vtx_y,
  output logic [DATA_W-1:0] vtx_z,
  output logic              vtx_last
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        state_q,      state_d;
  logic [ADDR_W-1:0] addr_q,       addr_d;
  logic              cs_q,         cs_d;
  logic [11:0]       issue_left_q, issue_left_d;  // words still to address
  logic [9:0]        count_q,      count_d;
  logic              rd_valid_q,   rd_valid_d;    // mem_readdata holds a word
  logic [1:0]        rphase_q,     rphase_d;      // x/y/z slot of that word
  logic [9:0]        rec_cnt_q,    rec_cnt_d;     // records assembled so far
  logic [DATA_W-1:0] x_hold_q,     x_hold_d;
  logic [DATA_W-1:0] y_hold_q,     y_hold_d;
  logic [DATA_W-1:0] vx_q,         vx_d;
  logic [DATA_W-1:0] vy_q,         vy_d;
  logic [DATA_W-1:0] vz_q,         vz_d;
  logic              vvalid_q,     vvalid_d;
  logic              vlast_q,      vlast_d;
  logic              busy_q,       busy_d;
  logic              done_q,       done_d;

  logic              w_slot_free;
  logic              w_stall;
  logic [11:0]       w_total_words;

  // A z word can only be retired into the output slot. When that slot is
  // still occupied, the whole read pipe freezes: the memory keeps presenting
  // the same word because its address register is clock-enabled off.
  assign w_slot_free   = !vvalid_q || vtx_ready;
  assign w_stall       = rd_valid_q && (rphase_q == 2'd2) && !w_slot_free;
  assign w_total_words = {2'b00, vertex_count} + {1'b0, vertex_count, 1'b0};

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cs_d         = cs_q;
    issue_left_d = issue_left_q;
    count_d      = count_q;
    rd_valid_d   = rd_valid_q;
    rphase_d     = rphase_q;
    rec_cnt_d    = rec_cnt_q;
    x_hold_d     = x_hold_q;
    y_hold_d     = y_hold_q;
    vx_d         = vx_q;
    vy_d         = vy_q;
    vz_d         = vz_q;
    vvalid_d     = vvalid_q;
    vlast_d      = vlast_q;
    busy_d       = busy_q;
    done_d       = 1'b0;

    // Output slot empties on handshake; a new capture below overrides this.
    if (vvalid_q && vtx_ready) begin
      vvalid_d = 1'b0;
      vlast_d  = 1'b0;
    end

    // Read return path: a word is present the cycle after an enabled
    // address cycle with chipselect.
    if (!w_stall) begin
      rd_valid_d = cs_q;
      if (rd_valid_q) begin
        case (rphase_q)
          2'd0: begin
            x_hold_d = mem_readdata;
            rphase_d = 2'd1;
          end
          2'd1: begin
            y_hold_d = mem_readdata;
            rphase_d = 2'd2;
          end
          default: begin
            vx_d      = x_hold_q;
            vy_d      = y_hold_q;
            vz_d      = mem_readdata;
            vvalid_d  = 1'b1;
            vlast_d   = (rec_cnt_q == count_q - 10'd1);
            rec_cnt_d = rec_cnt_q + 10'd1;
            rphase_d  = 2'd0;
          end
        endcase
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (vertex_count != 10'd0) begin
            state_d      = S_FETCH;
            busy_d       = 1'b1;
            addr_d       = base_addr;
            cs_d         = 1'b1;
            issue_left_d = w_total_words;
            count_d      = vertex_count;
            rec_cnt_d    = 10'd0;
            rphase_d     = 2'd0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_FETCH: begin
        // The address on the bus is consumed only on an enabled cycle.
        if (!w_stall) begin
          issue_left_d = issue_left_q - 12'd1;
          if (issue_left_q == 12'd1) begin
            cs_d    = 1'b0;
            state_d = S_DRAIN;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (vvalid_q && vtx_ready && vlast_q) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      cs_q         <= 1'b0;
      issue_left_q <= '0;
      count_q      <= '0;
      rd_valid_q   <= 1'b0;
      rphase_q     <= 2'd0;
      rec_cnt_q    <= '0;
      x_hold_q     <= '0;
      y_hold_q     <= '0;
      vx_q         <= '0;
      vy_q         <= '0;
      vz_q         <= '0;
      vvalid_q     <= 1'b0;
      vlast_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cs_q         <= cs_d;
      issue_left_q <= issue_left_d;
      count_q      <= count_d;
      rd_valid_q   <= rd_valid_d;
      rphase_q     <= rphase_d;
      rec_cnt_q    <= rec_cnt_d;
      x_hold_q     <= x_hold_d;
      y_hold_q     <= y_hold_d;
      vx_q         <= vx_d;
      vy_q         <= vy_d;
      vz_q         <= vz_d;
      vvalid_q     <= vvalid_d;
      vlast_q      <= vlast_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign mem_address    = addr_q;
  assign mem_byteenable = 4'hF;
  assign mem_chipselect = cs_q;
  assign mem_write      = 1'b0;
  assign mem_writedata  = '0;
  assign mem_clken      = !w_stall;
  assign vtx_valid      = vvalid_q;
  assign vtx_x          = vx_q;
  assign vtx_y          = vy_q;
  assign vtx_z          = vz_q;
  assign vtx_last       = vlast_q;

endmodule
`default_nettype wire

// File: tb/tb_vertex_fetch_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_vertex_fetch_reader
// Purpose  : Self-checking bench for vertex_fetch_reader. Models the on-chip
//            memory, logs bus/stream activity and compares each job against
//            the record layout x,y,z at base+3k (mod 1024).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vertex_fetch_reader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [9:0]  vertex_count = '0;
  logic        busy, done, mem_chipselect, mem_write, mem_clken;
  logic [9:0]  mem_address;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata, mem_readdata;
  logic        vtx_valid, vtx_last;
  logic        vtx_ready = 1'b1;
  logic [31:0] vtx_x, vtx_y, vtx_z;

  vertex_fetch_reader #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .vertex_count(vertex_count), .busy(busy), .done(done),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .vtx_valid(vtx_valid), .vtx_ready(vtx_ready),
    .vtx_x(vtx_x), .vtx_y(vtx_y), .vtx_z(vtx_z), .vtx_last(vtx_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Memory: registered address (clock-enabled), data one cycle later.
  logic [31:0] mem [0:1023];
  logic [9:0]  mem_areg = '0;
  always @(posedge clk) if (mem_clken) mem_areg <= mem_address;
  assign mem_readdata = mem[mem_areg];

  // Activity logs filled by the monitor.
  int          addr_log[$];
  int          addr_cyc[$];
  logic [31:0] bx[$], by[$], bz[$];
  logic        bl[$];
  int          bcyc[$];
  int          done_cyc[$];
  logic        done_busy;
  int          stall_cnt, busy_cnt, hold_err, we_cnt;
  logic        prev_hold = 1'b0;
  logic [96:0] prev_data = '0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_chipselect && mem_clken) begin
        addr_log.push_back(int'(mem_address));
        addr_cyc.push_back(cyc);
      end
      if (!mem_clken) stall_cnt++;
      if (busy) busy_cnt++;
      if (mem_write || mem_byteenable != 4'hF || mem_writedata != 0) we_cnt++;
      if (done) begin
        done_cyc.push_back(cyc);
        done_busy = busy;
      end
      if (vtx_valid && vtx_ready) begin
        bx.push_back(vtx_x); by.push_back(vtx_y); bz.push_back(vtx_z);
        bl.push_back(vtx_last); bcyc.push_back(cyc);
      end
      if (prev_hold && (!vtx_valid || prev_data != {vtx_last, vtx_x, vtx_y, vtx_z}))
        hold_err++;
      prev_hold = vtx_valid && !vtx_ready;
      prev_data = {vtx_last, vtx_x, vtx_y, vtx_z};
    end else begin
      prev_hold = 1'b0;
    end
  end

  int vecs = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    addr_log.delete(); addr_cyc.delete();
    bx.delete(); by.delete(); bz.delete(); bl.delete(); bcyc.delete();
    done_cyc.delete();
    done_busy = 1'bx;
    stall_cnt = 0; busy_cnt = 0; hold_err = 0; we_cnt = 0;
  endtask

  function automatic logic rdy(input int mode, input int k);
    if (mode == 1) return !(k >= 5 && k <= 9);
    if (mode == 2) return ($urandom_range(0, 3) != 0);
    return 1'b1;
  endfunction

  // Called at posedge+1; the start cycle is returned in t0.
  task automatic run_job(input int base, input int cnt, input int mode,
                         input int extra_start_at, output int t0);
    clear_logs();
    base_addr    = 10'(base);
    vertex_count = 10'(cnt);
    vtx_ready    = 1'b1;
    start        = 1'b1;
    t0           = cyc;
    @(posedge clk); #1;
    for (int k = 1; k < 300; k++) begin
      vtx_ready = rdy(mode, k);
      if (k == extra_start_at) begin
        start        = 1'b1;
        base_addr    = 10'(base + 100);
        vertex_count = 10'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done_cyc.size() != 0) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    start     = 1'b0;
    vtx_ready = 1'b1;
  endtask

  task automatic check_job(input string nm, input int base, input int cnt,
                           input int t0, input bit timed);
    int n;
    chk({nm, " done_count"}, done_cyc.size(), 1);
    chk({nm, " beat_count"}, bx.size(), cnt);
    chk({nm, " addr_count"}, addr_log.size(), 3 * cnt);
    chk({nm, " hold_err"}, hold_err, 0);
    chk({nm, " const_outputs"}, we_cnt, 0);
    n = (bx.size() < cnt) ? bx.size() : cnt;
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s x[%0d]", nm, k), bx[k], mem[(base + 3 * k) % 1024]);
      chk($sformatf("%s y[%0d]", nm, k), by[k], mem[(base + 3 * k + 1) % 1024]);
      chk($sformatf("%s z[%0d]", nm, k), bz[k], mem[(base + 3 * k + 2) % 1024]);
      chk($sformatf("%s last[%0d]", nm, k), bl[k], (k == cnt - 1));
      if (timed) chk($sformatf("%s beat_cyc[%0d]", nm, k), bcyc[k] - t0, 5 + 3 * k);
    end
    n = (addr_log.size() < 3 * cnt) ? addr_log.size() : 3 * cnt;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s addr[%0d]", nm, i), addr_log[i], (base + i) % 1024);
      if (timed) chk($sformatf("%s addr_cyc[%0d]", nm, i), addr_cyc[i] - t0, 1 + i);
    end
    if (done_cyc.size() > 0 && bcyc.size() > 0) begin
      chk({nm, " done_after_last"}, done_cyc[0], bcyc[$] + 1);
      chk({nm, " busy_at_done"}, done_busy, 1'b0);
      chk({nm, " busy_cycles"}, busy_cnt, done_cyc[0] - t0 - 1);
    end
    if (timed) begin
      chk({nm, " stalls"}, stall_cnt, 0);
      if (done_cyc.size() > 0) chk({nm, " done_cyc"}, done_cyc[0] - t0, 3 * cnt + 3);
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, " mem_address"}, mem_address, 0);
    chk({nm, " mem_chipselect"}, mem_chipselect, 0);
    chk({nm, " mem_clken"}, mem_clken, 1);
    chk({nm, " busy"}, busy, 0);
    chk({nm, " done"}, done, 0);
    chk({nm, " vtx_valid"}, vtx_valid, 0);
    chk({nm, " vtx_x"}, vtx_x, 0);
    chk({nm, " vtx_y"}, vtx_y, 0);
    chk({nm, " vtx_z"}, vtx_z, 0);
    chk({nm, " vtx_last"}, vtx_last, 0);
  endtask

  initial begin
    int t0, b, c;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;

    // Reset state.
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Single vertex with fixed data.
    mem[16] = 32'h11; mem[17] = 32'h22; mem[18] = 32'h33;
    run_job(16, 1, 0, -1, t0);
    check_job("single", 16, 1, t0, 1'b1);
    if (bx.size() > 0) begin
      chk("single x_const", bx[0], 32'h11);
      chk("single y_const", by[0], 32'h22);
      chk("single z_const", bz[0], 32'h33);
    end

    // Streaming four vertices.
    b = $urandom_range(0, 1000);
    run_job(b, 4, 0, -1, t0);
    check_job("stream", b, 4, t0, 1'b1);

    // Backpressure: ready low for T+5..T+9.
    b = $urandom_range(0, 1000);
    run_job(b, 3, 1, -1, t0);
    check_job("bp", b, 3, t0, 1'b0);
    chk("bp stall_cycles", stall_cnt, 3);
    if (bcyc.size() == 3) begin
      chk("bp beat0_cyc", bcyc[0] - t0, 10);
      chk("bp beat1_cyc", bcyc[1] - t0, 11);
      chk("bp beat2_cyc", bcyc[2] - t0, 14);
    end

    // Address wrap.
    run_job(10'h3FE, 2, 0, -1, t0);
    check_job("wrap", 10'h3FE, 2, t0, 1'b1);

    // Zero count.
    run_job(5, 0, 0, -1, t0);
    chk("zero done_count", done_cyc.size(), 1);
    if (done_cyc.size() > 0) chk("zero done_cyc", done_cyc[0] - t0, 1);
    chk("zero chipselects", addr_log.size(), 0);
    chk("zero busy_cycles", busy_cnt, 0);

    // Start pulsed while busy is ignored.
    b = $urandom_range(0, 1000);
    run_job(b, 2, 0, 4, t0);
    check_job("busy_start", b, 2, t0, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    chk("busy_start beats_after", bx.size(), 2);
    chk("busy_start idle_busy", busy, 0);

    // Reset in the middle of a FETCH.
    clear_logs();
    base_addr = 10'd200; vertex_count = 10'd5; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #4 reset_n = 1'b0;
    #1 chk_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("midreset no_done", done_cyc.size(), 0);
    chk("midreset no_beats", bx.size(), 0);
    mem[40] = 32'h11; mem[41] = 32'h22; mem[42] = 32'h33;
    run_job(40, 1, 0, -1, t0);
    check_job("after_reset", 40, 1, t0, 1'b1);

    // Randomised jobs with random backpressure.
    for (int j = 0; j < 6; j++) begin
      b = $urandom_range(0, 1023);
      c = $urandom_range(1, 8);
      run_job(b, c, 2, -1, t0);
      check_job($sformatf("rand%0d", j), b, c, t0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
